// File: rtl/switch_stats_monitor.sv
// switch_stats_monitor: per-port drop / expected / delivered accounting for an N-port switch.
// Define SWITCH_STATS_SAT_EN for saturating counters; by default counters wrap.
module switch_stats_monitor #(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           valid_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] target_in,
    input  logic [NUM_PORTS-1:0]           fifo_full,
    input  logic [NUM_PORTS-1:0]           valid_out,
    input  logic                           clr,
    input  logic                           rd_req,
    input  logic [3:0]                     rd_port,
    input  logic [1:0]                     rd_sel,
    output logic                           rd_valid,
    output logic [CNT_W-1:0]               rd_data,
    output logic                           rd_err,
    output logic                           ovf
);
    localparam int INC_W = $clog2(NUM_PORTS + 1);

    logic [CNT_W-1:0] drops     [NUM_PORTS];
    logic [CNT_W-1:0] expected  [NUM_PORTS];
    logic [CNT_W-1:0] delivered [NUM_PORTS];
    logic [CNT_W-1:0] pending   [NUM_PORTS];
    logic [INC_W-1:0] drop_inc  [NUM_PORTS];
    logic [INC_W-1:0] exp_inc   [NUM_PORTS];
    logic [CNT_W:0]   drop_sum  [NUM_PORTS];
    logic [CNT_W:0]   exp_sum   [NUM_PORTS];
    logic [CNT_W:0]   dlv_sum   [NUM_PORTS];
    logic             ovf_evt;
    logic [CNT_W-1:0] rd_sel_val;
    logic             rd_oob;

    function automatic logic [CNT_W-1:0] clip(input logic [CNT_W:0] s);
`ifdef SWITCH_STATS_SAT_EN
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
`else
        return s[CNT_W-1:0];
`endif
    endfunction

    // A dropped packet is weighted by its fan-out; an accepted one credits each target.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop_inc[p] = '0;
            exp_inc[p]  = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (valid_in[i] && target_in[i*NUM_PORTS + j]) begin
                    if (fifo_full[i]) drop_inc[i] = drop_inc[i] + INC_W'(1);
                    else              exp_inc[j]  = exp_inc[j] + INC_W'(1);
                end
            end
        end
    end

    always_comb begin
        ovf_evt = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop_sum[p] = {1'b0, drops[p]}     + (CNT_W+1)'(drop_inc[p]);
            exp_sum[p]  = {1'b0, expected[p]}  + (CNT_W+1)'(exp_inc[p]);
            dlv_sum[p]  = {1'b0, delivered[p]} + (CNT_W+1)'(valid_out[p]);
            pending[p]  = expected[p] - delivered[p];
            ovf_evt     = ovf_evt | drop_sum[p][CNT_W] | exp_sum[p][CNT_W] | dlv_sum[p][CNT_W];
        end
    end

    // Readout handshake: rd_req has no ready; every request is accepted and answered with
    // rd_valid exactly one cycle later, carrying the counter value before that edge's update.
    always_comb begin
        rd_sel_val = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_port == 4'(p)) begin
                case (rd_sel)
                    2'd0: rd_sel_val = drops[p];
                    2'd1: rd_sel_val = expected[p];
                    2'd2: rd_sel_val = delivered[p];
                    2'd3: rd_sel_val = pending[p];
                endcase
            end
        end
    end

    assign rd_oob = {1'b0, rd_port} >= 5'(NUM_PORTS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                drops[p]     <= '0;
                expected[p]  <= '0;
                delivered[p] <= '0;
            end
            ovf      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_err   <= rd_req & rd_oob;
            if (rd_req) rd_data <= rd_sel_val;
            // clr still lets a coincident read return the pre-clear value
            if (clr) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    drops[p]     <= '0;
                    expected[p]  <= '0;
                    delivered[p] <= '0;
                end
                ovf <= 1'b0;
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    drops[p]     <= clip(drop_sum[p]);
                    expected[p]  <= clip(exp_sum[p]);
                    delivered[p] <= clip(dlv_sum[p]);
                end
                if (ovf_evt) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_stats_monitor.sv
// Self-checking bench for switch_stats_monitor: directed scenarios plus random traffic
// checked against a counter-level reference model.
module tb_switch_stats_monitor;
    localparam int NP   = 8;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    valid_in;
    logic [NP*NP-1:0] target_in;
    logic [NP-1:0]    fifo_full;
    logic [NP-1:0]    valid_out;
    logic             clr;
    logic             rd_req;
    logic [3:0]       rd_port;
    logic [1:0]       rd_sel;
    logic             rd_valid;
    logic [CW-1:0]    rd_data;
    logic             rd_err;
    logic             ovf;

    switch_stats_monitor #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .target_in(target_in),
        .fifo_full(fifo_full), .valid_out(valid_out), .clr(clr), .rd_req(rd_req),
        .rd_port(rd_port), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_err(rd_err), .ovf(ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard
    int            m_drops [NP];
    int            m_exp   [NP];
    int            m_dlv   [NP];
    bit            m_ovf;
    logic [CW-1:0] last_data;
    logic [CW-1:0] exp_q[$];
    logic          err_q[$];
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int next_cnt(input int c, input int inc);
        if (c + inc <= MAXV) return c + inc;
`ifdef SWITCH_STATS_SAT_EN
        return MAXV;
`else
        return (c + inc) % (MAXV + 1);
`endif
    endfunction

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            m_drops[p] = 0;
            m_exp[p]   = 0;
            m_dlv[p]   = 0;
        end
        m_ovf = 0;
    endtask

    task automatic apply_events();
        for (int i = 0; i < NP; i++) begin
            int w;
            w = $countones(target_in[i*NP +: NP]);
            if (valid_in[i] && fifo_full[i]) begin
                if (m_drops[i] + w > MAXV) m_ovf = 1;
                m_drops[i] = next_cnt(m_drops[i], w);
            end
        end
        for (int j = 0; j < NP; j++) begin
            int n;
            n = 0;
            for (int i = 0; i < NP; i++)
                if (valid_in[i] && !fifo_full[i] && target_in[i*NP + j]) n++;
            if (m_exp[j] + n > MAXV) m_ovf = 1;
            m_exp[j] = next_cnt(m_exp[j], n);
            if (valid_out[j]) begin
                if (m_dlv[j] + 1 > MAXV) m_ovf = 1;
                m_dlv[j] = next_cnt(m_dlv[j], 1);
            end
        end
    endtask

    task automatic model_read(input logic [3:0] p, input logic [1:0] s,
                              output logic [CW-1:0] v, output logic e);
        e = (int'(p) >= NP);
        v = '0;
        if (!e) begin
            case (s)
                2'd0: v = CW'(m_drops[p]);
                2'd1: v = CW'(m_exp[p]);
                2'd2: v = CW'(m_dlv[p]);
                2'd3: v = CW'(m_exp[p] - m_dlv[p]);
            endcase
        end
    endtask

    // driver: one clock edge with model update and output checks
    task automatic cycle();
        logic          req;
        logic [CW-1:0] rv;
        logic          re;
        req = rd_req && !rst;
        if (req) begin
            model_read(rd_port, rd_sel, rv, re);
            exp_q.push_back(rv);
            err_q.push_back(re);
        end
        @(posedge clk);
        if (rst) begin
            clear_model();
            last_data = '0;
        end else if (clr) begin
            clear_model();
        end else begin
            apply_events();
        end
        #1;
        check("rd_valid", rd_valid, req);
        if (req) begin
            rv = exp_q.pop_front();
            re = err_q.pop_front();
            check("rd_data", rd_data, rv);
            check("rd_err", rd_err, re);
            last_data = rv;
        end else begin
            check("rd_err_idle", rd_err, 0);
            check("rd_data_hold", rd_data, last_data);
        end
        check("ovf", ovf, m_ovf);
    endtask

    task automatic idle();
        valid_in  = '0;
        target_in = '0;
        fifo_full = '0;
        valid_out = '0;
        clr       = 1'b0;
        rd_req    = 1'b0;
        rd_port   = '0;
        rd_sel    = '0;
    endtask

    task automatic read_check(input string tag, input int p, input int s, input logic [31:0] want);
        rd_req  = 1'b1;
        rd_port = 4'(p);
        rd_sel  = 2'(s);
        cycle();
        check(tag, rd_data, want);
        rd_req = 1'b0;
    endtask

    int pend_sum;
    bit busy;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_data = '0;
        clear_model();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("reset_rd_data", rd_data, 0);
        check("reset_ovf", ovf, 0);

        // drop weighting: mask 1011 dropped for three cycles
        valid_in[0] = 1'b1;
        fifo_full[0] = 1'b1;
        target_in[0 +: NP] = 8'b0000_1011;
        repeat (3) cycle();
        idle();
        read_check("drops0_weighted", 0, 0, 9);
        read_check("exp0_after_drop", 0, 1, 0);
        read_check("exp3_after_drop", 3, 1, 0);
        check("ovf_after_drop", ovf, 0);

        // fan-in of four accepted packets onto port 2, then three deliveries
        for (int i = 0; i < 4; i++) begin
            valid_in[i] = 1'b1;
            target_in[i*NP +: NP] = 8'h04;
        end
        cycle();
        idle();
        read_check("exp2_fanin", 2, 1, 4);
        valid_out[2] = 1'b1;
        repeat (3) cycle();
        idle();
        read_check("dlv2", 2, 2, 3);
        read_check("pend2", 2, 3, 1);

        // snapshot: read coincides with another accepted packet for port 2
        valid_in[5] = 1'b1;
        target_in[5*NP +: NP] = 8'h04;
        read_check("snap_pre_update", 2, 1, 4);
        idle();
        read_check("snap_follow_up", 2, 1, 5);

        // clear wins over a coincident drop; coincident read returns pre-clear value
        clr = 1'b1;
        valid_in[1] = 1'b1;
        fifo_full[1] = 1'b1;
        target_in[NP +: NP] = 8'hFF;
        read_check("clr_pre_value", 2, 1, 5);
        idle();
        read_check("clr_drops1", 1, 0, 0);
        read_check("clr_exp2", 2, 1, 0);
        read_check("oob_data", 9, 0, 0);
        check("oob_err", rd_err, 1);
        read_check("edge_port_data", 7, 1, 0);
        check("edge_port_err", rd_err, 0);
        read_check("oob_first", NP, 2, 0);
        check("oob_first_err", rd_err, 1);

        // overflow on delivered[3]
        valid_out[3] = 1'b1;
        repeat (255) cycle();
        check("ovf_at_max", ovf, 0);
        cycle();
        idle();
        check("ovf_wrap_edge", ovf, 1);
`ifdef SWITCH_STATS_SAT_EN
        read_check("dlv3_overflow", 3, 2, MAXV);
`else
        read_check("dlv3_overflow", 3, 2, 0);
`endif
        clr = 1'b1;
        cycle();
        idle();
        check("ovf_cleared", ovf, 0);

        // random traffic; deliveries only where the model shows outstanding packets
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < NP; i++) begin
                valid_in[i]  = ($urandom_range(0, 3) == 0);
                fifo_full[i] = ($urandom_range(0, 3) == 0);
                target_in[i*NP +: NP] = NP'($urandom_range(0, 255) & $urandom_range(0, 255));
                valid_out[i] = (m_exp[i] > m_dlv[i]) && ($urandom_range(0, 1) == 1);
            end
            rd_req  = ($urandom_range(0, 1) == 1);
            rd_port = 4'($urandom_range(0, 9));
            rd_sel  = 2'($urandom_range(0, 3));
            cycle();
        end
        idle();

        // drain, bounded
        for (int c = 0; c < 300; c++) begin
            busy = 0;
            for (int j = 0; j < NP; j++) begin
                valid_out[j] = (m_exp[j] > m_dlv[j]);
                if (valid_out[j]) busy = 1;
            end
            if (!busy) break;
            cycle();
        end
        check("drain_done", busy, 0);
        idle();

        pend_sum = 0;
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < 3; s++) begin
                rd_req  = 1'b1;
                rd_port = 4'(p);
                rd_sel  = 2'(s);
                cycle();
            end
            rd_sel = 2'd3;
            cycle();
            pend_sum += int'(rd_data);
        end
        idle();
        check("pending_sum_drained", pend_sum, 0);

        // reset during a readout suppresses the response
        rd_req  = 1'b1;
        rd_port = 4'd0;
        rd_sel  = 2'd0;
        rst     = 1'b1;
        cycle();
        check("rst_mid_read_valid", rd_valid, 0);
        check("rst_mid_read_data", rd_data, 0);
        rst = 1'b0;
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
